// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
// Shared constants and types for the IF stage: bubble and halt encodings,
// MIPS primary opcodes, and the fetch FSM state encoding.
package instruction_fetch_pkg;

  // add $0,$0,$0 -- used as the pipeline bubble
  localparam logic [31:0] NOP_BUBBLE        = 32'h0000_0020;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
// Groups the IF-stage control inputs, the instruction loader port and the
// IF/ID register outputs.
//   master : the fetch stage (drives IR, PC, fetch_pc, halted)
//   slave  : decode / loader side (drives PC2, stall, imem_*)
interface instruction_fetch_if #(
  parameter int IMEM_AW = 6
);
  logic [31:0]        PC2;
  logic               stall;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic [31:0]        IR;
  logic [31:0]        PC;
  logic [31:0]        fetch_pc;
  logic               halted;

  modport master (
    input  PC2, stall, imem_we, imem_waddr, imem_wdata,
    output IR, PC, fetch_pc, halted
  );

  modport slave (
    output PC2, stall, imem_we, imem_waddr, imem_wdata,
    input  IR, PC, fetch_pc, halted
  );
endinterface

// File: rtl/instruction_fetch_imem_rom.sv
// imem_rom
// Instruction memory: DEPTH x 32 words, asynchronous read, synchronous write.
// A same-cycle write and read of one word returns the old word.
// Ports:
//   clk       clock
//   we_i      write enable
//   waddr_i   write word address
//   wdata_i   write data
//   raddr_i   read word address
//   rdata_o   read data (combinational)
module imem_rom #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// IF stage of the 5-stage MIPS pipeline. Owns the PC and the instruction
// memory, and drives the IF/ID register (IR, PC) for decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | fetching; redirect > stall > sequential fetch
// ST_HALT | halt word seen; IR held at bubble until a redirect arrives
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  master modport: PC2/stall/imem_* in, IR/PC/fetch_pc/halted out
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter int          IMEM_AW    = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc2_q;
  logic [31:0]  imem_rdata;
  logic [31:0]  pc_plus4;
  logic         redirect;

  imem_rom #(
    .DEPTH (IMEM_DEPTH),
    .AW    (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .we_i    (bus.imem_we),
    .waddr_i (bus.imem_waddr),
    .wdata_i (bus.imem_wdata),
    .raddr_i (fetch_pc_q[IMEM_AW+1:2]),
    .rdata_o (imem_rdata)
  );

  // Decode holds PC2 for several cycles; only a change to a nonzero value
  // counts as a new redirect, so a sticky target is taken exactly once.
  assign redirect = (bus.PC2 != 32'd0) && (bus.PC2 != pc2_q);
  assign pc_plus4 = fetch_pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          fetch_pc_d = bus.PC2;
          ir_d       = NOP_BUBBLE;
          pc_d       = 32'd0;
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
          if (imem_rdata == HALT_WORD) begin
            // fetch_pc parks on the halt word
            ir_d    = NOP_BUBBLE;
            state_d = ST_HALT;
          end else begin
            ir_d       = imem_rdata;
            fetch_pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        ir_d = NOP_BUBBLE;
        if (redirect) begin
          fetch_pc_d = bus.PC2;
          pc_d       = 32'd0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      ir_q       <= NOP_BUBBLE;
      pc_q       <= 32'd0;
      pc2_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      pc2_q      <= bus.PC2;
    end
  end

  assign bus.IR       = ir_q;
  assign bus.PC       = pc_q;
  assign bus.fetch_pc = fetch_pc_q;
  assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0020;
  localparam logic [31:0] M0  = 32'h0022_1820;
  localparam logic [31:0] M1  = 32'h0022_1822;
  localparam logic [31:0] M2  = 32'h0022_182A;
  localparam logic [31:0] M3  = 32'hFFFF_FFFF;
  localparam logic [31:0] M4  = 32'h8C22_0004;
  localparam logic [31:0] M5  = 32'hAC22_0008;
  localparam logic [31:0] M6  = 32'h1022_0003;
  localparam logic [31:0] M7  = 32'h00A6_3820;
  localparam logic [31:0] M8  = 32'h0043_1020;
  localparam logic [31:0] M9  = 32'hFFFF_FFFF;
  localparam logic [31:0] M63 = 32'h3C01_0001;
  localparam logic [31:0] NEW1 = 32'h1234_5678;

  logic clk;
  logic rst;

  instruction_fetch_if #(.IMEM_AW(6)) bus ();

  instruction_fetch #(
    .IMEM_DEPTH (64),
    .IMEM_AW    (6),
    .RESET_PC   (32'h0000_0000),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] fpc;
    logic        halted;
    logic        chk_pc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec;
  int   n_bad;

  // Monitor: one expectation describes the IF/ID state after one edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (bus.IR !== mon_e.ir || bus.fetch_pc !== mon_e.fpc ||
          bus.halted !== mon_e.halted || (mon_e.chk_pc && bus.PC !== mon_e.pc)) begin
        n_bad++;
        $display("FAIL %s: got IR=%08h PC=%08h fetch_pc=%08h halted=%0b, want IR=%08h PC=%08h%s fetch_pc=%08h halted=%0b",
                 mon_e.name, bus.IR, bus.PC, bus.fetch_pc, bus.halted,
                 mon_e.ir, mon_e.pc, mon_e.chk_pc ? "" : "(ignored)", mon_e.fpc, mon_e.halted);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] pc2, input logic st,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] fpc,
                      input logic h, input logic cpc, input string nm);
    exp_t e;
    rst            = r;
    bus.PC2        = pc2;
    bus.stall      = st;
    bus.imem_we    = we;
    bus.imem_waddr = wa;
    bus.imem_wdata = wd;
    e.ir = ir; e.pc = pc; e.fpc = fpc; e.halted = h; e.chk_pc = cpc; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] pc2, input logic st,
                     input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] fpc,
                     input logic h, input logic cpc, input string nm);
    step(1'b0, pc2, st, 1'b0, 6'd0, 32'd0, ir, pc, fpc, h, cpc, nm);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    step(1'b1, 32'd0, 1'b0, 1'b1, a, d, NOP, 32'd0, 32'd0, 1'b0, 1'b1, "reset_load");
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.PC2 = 32'd0; bus.stall = 1'b0;
    bus.imem_we = 1'b0; bus.imem_waddr = 6'd0; bus.imem_wdata = 32'd0;
    @(negedge clk);

    load(6'd0, M0); load(6'd1, M1); load(6'd2, M2); load(6'd3, M3);
    load(6'd4, M4); load(6'd5, M5); load(6'd6, M6); load(6'd7, M7);
    load(6'd8, M8); load(6'd9, M9); load(6'd63, M63);

    // straight-line fetch into halt
    run(32'h0, 0, M0, 32'h04, 32'h04, 0, 1, "seq_w0");
    run(32'h0, 0, M1, 32'h08, 32'h08, 0, 1, "seq_w1");
    run(32'h0, 0, M2, 32'h0C, 32'h0C, 0, 1, "seq_w2");
    run(32'h0, 0, NOP, 32'h0, 32'h0C, 1, 0, "halt_enter");
    run(32'h0, 1, NOP, 32'h0, 32'h0C, 1, 0, "halt_ignores_stall");
    // leave halt
    run(32'h04, 0, NOP, 32'h0, 32'h04, 0, 0, "halt_redirect");
    run(32'h0, 0, M1, 32'h08, 32'h08, 0, 1, "halt_resume_w1");
    // sticky PC2 held 5 cycles
    run(32'h10, 0, NOP, 32'h0, 32'h10, 0, 1, "redir_bubble");
    run(32'h10, 0, M4, 32'h14, 32'h14, 0, 1, "redir_target_w4");
    run(32'h10, 0, M5, 32'h18, 32'h18, 0, 1, "sticky_no_retake_1");
    run(32'h10, 0, M6, 32'h1C, 32'h1C, 0, 1, "sticky_no_retake_2");
    run(32'h10, 0, M7, 32'h20, 32'h20, 0, 1, "sticky_no_retake_3");
    run(32'h0, 0, M8, 32'h24, 32'h24, 0, 1, "seq_w8");
    // redirect beats stall
    run(32'h20, 1, NOP, 32'h0, 32'h20, 0, 1, "redir_over_stall");
    run(32'h0, 0, M8, 32'h24, 32'h24, 0, 1, "after_redir_w8");
    // stall for 3 cycles with IR = M1
    run(32'h04, 0, NOP, 32'h0, 32'h04, 0, 1, "redir_to_4");
    run(32'h0, 0, M1, 32'h08, 32'h08, 0, 1, "pre_stall_w1");
    run(32'h0, 1, M1, 32'h08, 32'h08, 0, 1, "stall_1");
    run(32'h0, 1, M1, 32'h08, 32'h08, 0, 1, "stall_2");
    run(32'h0, 1, M1, 32'h08, 32'h08, 0, 1, "stall_3");
    run(32'h0, 0, M2, 32'h0C, 32'h0C, 0, 1, "post_stall_w2");
    // index wrap at IMEM_DEPTH*4
    run(32'hFC, 0, NOP, 32'h0, 32'hFC, 0, 1, "redir_fc");
    run(32'h0, 0, M63, 32'h100, 32'h100, 0, 1, "fetch_w63");
    run(32'h0, 0, M0, 32'h104, 32'h104, 0, 1, "wrap_idx0");
    // 32-bit PC wrap
    run(32'hFFFF_FFFC, 0, NOP, 32'h0, 32'hFFFF_FFFC, 0, 1, "redir_top");
    run(32'h0, 0, M63, 32'h0, 32'h0, 0, 1, "pc_wrap_2e32");
    run(32'h0, 0, M0, 32'h04, 32'h04, 0, 1, "after_pc_wrap");
    // write the word being read: old word returned, new word later
    step(1'b0, 32'h0, 1'b0, 1'b1, 6'd1, NEW1, M1, 32'h08, 32'h08, 1'b0, 1'b1, "wr_rd_same_old");
    run(32'h04, 0, NOP, 32'h0, 32'h04, 0, 1, "redir_reread");
    run(32'h0, 0, NEW1, 32'h08, 32'h08, 0, 1, "reread_new");
    // reset mid-run beats stall and redirect
    step(1'b1, 32'h40, 1'b1, 1'b0, 6'd0, 32'd0, NOP, 32'h0, 32'h0, 1'b0, 1'b1, "reset_midrun");
    run(32'h0, 0, M0, 32'h04, 32'h04, 0, 1, "post_reset_w0");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
